// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multicycle main control FSM:
//               opcodes, ALU-operation select codes (also consumed by the
//               ALU control decoder), datapath mux encodings, state enum.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    // ALU-operation class handed to the ALU control decoder
    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    // ALU operand B select
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADDR  = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_RWB      = 4'd8,
        ST_EXEC_I   = 4'd9,
        ST_IWB      = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_main_control_opdec.sv
`default_nettype none
// ============================================================================
// Module      : mc_opdec
// Description : Combinational opcode decoder. Maps an opcode to the state
//               that follows DECODE, a legal flag, the immediate-class ALU
//               select and a store flag (selects MEMWRITE after MEMADDR).
// Ports       : opcode_i   - 6-bit opcode
//               next_o     - dispatch state out of DECODE (ST_TRAP if illegal)
//               legal_o    - opcode is one of the supported instructions
//               sel_alu_o  - ALU class used in EXEC_I (ADD for non-I ops)
//               is_store_o - opcode is SW
// Revision    : 1.0 - initial release
// ============================================================================
module mc_opdec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode_i,
    output state_t     next_o,
    output logic       legal_o,
    output logic [2:0] sel_alu_o,
    output logic       is_store_o
);

    always_comb begin
        next_o     = ST_TRAP;
        legal_o    = 1'b1;
        sel_alu_o  = ALU_ADD;
        is_store_o = 1'b0;
        case (opcode_i)
            OP_LW:   next_o = ST_MEMADDR;
            OP_SW: begin
                next_o     = ST_MEMADDR;
                is_store_o = 1'b1;
            end
            OP_R:    next_o = ST_EXEC_R;
            OP_ADDI: next_o = ST_EXEC_I;
            OP_ORI: begin
                next_o    = ST_EXEC_I;
                sel_alu_o = ALU_OR;
            end
            OP_ANDI: begin
                next_o    = ST_EXEC_I;
                sel_alu_o = ALU_AND;
            end
            OP_SLTI: begin
                next_o    = ST_EXEC_I;
                sel_alu_o = ALU_SLT;
            end
            OP_BEQ:  next_o = ST_BRANCH;
            OP_J:    next_o = ST_JUMP;
            default: legal_o = 1'b0;
        endcase
    end

endmodule : mc_opdec
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_control
// Description : Multicycle main control FSM for the MIPS-subset core.
//               Sequences fetch/decode/execute/memory/writeback, drives the
//               ALU-operation class and all datapath enables/muxes, and
//               counts retired instructions. Outputs are Moore, except the
//               FETCH ir_write/pc_write which qualify on mem_ready.
// Ports       : clk, rst_n (async active-low)
//               opcode, mem_ready            - inputs
//               sel_alu, pc_*, i_or_d, mem_*, ir_write, reg_*, mem_to_reg,
//               alu_src_a/b                  - datapath control
//               illegal                      - sticky illegal-opcode flag
//               instr_count                  - retired instructions (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_control
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [2:0]       sel_alu,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state_q, state_d;
    logic [5:0]         op_q, op_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               w_retire;

    // Dispatch decode on the live opcode (used only in DECODE)
    state_t             w_dec_next;
    logic               w_dec_legal;
    logic [2:0]         w_dec_sel;
    logic               w_dec_store;

    // Decode of the latched opcode for the later cycles of the instruction
    state_t             w_op_next;
    logic               w_op_legal;
    logic [2:0]         w_op_sel;
    logic               w_op_store;

    mc_opdec u_dec_in (
        .opcode_i   (opcode),
        .next_o     (w_dec_next),
        .legal_o    (w_dec_legal),
        .sel_alu_o  (w_dec_sel),
        .is_store_o (w_dec_store)
    );

    mc_opdec u_dec_op (
        .opcode_i   (op_q),
        .next_o     (w_op_next),
        .legal_o    (w_op_legal),
        .sel_alu_o  (w_op_sel),
        .is_store_o (w_op_store)
    );

    // Decoder outputs that this FSM has no use for in the given context
    logic w_unused_dec;
    assign w_unused_dec = ^{w_dec_sel, w_dec_store, w_op_next, w_op_legal};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RESET;
            op_q          <= '0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        illegal_d     = illegal_q;
        w_retire      = 1'b0;
        sel_alu       = ALU_RTYPE;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                sel_alu   = ALU_ADD;
                // IR and PC load only on the cycle the read completes
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch target into ALUOut
                alu_src_b = SRCB_IMM_SH2;
                sel_alu   = ALU_ADD;
                op_d      = opcode;
                state_d   = w_dec_next;
                if (!w_dec_legal) begin
                    illegal_d = 1'b1;
                end
            end
            ST_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                sel_alu   = ALU_ADD;
                state_d   = w_op_store ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
                w_retire   = 1'b1;
            end
            ST_MEMWRITE: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    state_d  = ST_FETCH;
                    w_retire = 1'b1;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REGB;
                sel_alu   = ALU_RTYPE;
                state_d   = ST_RWB;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
                w_retire  = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                sel_alu   = w_op_sel;
                state_d   = ST_IWB;
            end
            ST_IWB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
                w_retire  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REGB;
                sel_alu       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                state_d       = ST_FETCH;
                w_retire      = 1'b1;
            end
            ST_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                state_d  = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_RESET;
        endcase

        instr_count_d = instr_count_q;
        if (w_retire) begin
            instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign illegal     = illegal_q;
    assign instr_count = instr_count_q;

endmodule : mc_main_control
`default_nettype wire

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multicycle main control FSM for the MIPS-subset core.
- Sits directly upstream of the ALU control decoder.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback over several cycles.
- Drives the 3-bit ALU-operation select consumed by the ALU control decoder, plus all datapath enables and muxes. Waits on a memory-ready handshake.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
mem_ready  in  1  memory completes current read/write this cycle
sel_alu  out  3  ALU-operation class to ALU control decoder
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
i_or_d  out  1  0 PC addresses memory, 1 ALUOut addresses memory
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_dst  out  1  0 rt, 1 rd
mem_to_reg  out  1  0 ALUOut, 1 MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 PC, 1 reg A
alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
illegal  out  1  sticky illegal-opcode flag
instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset and state register
  - Async on rst_n=0: state=RESET, op_q=0, illegal=0, instr_count=0.
  - RESET drives all outputs 0, including sel_alu=000 and muxes=0.
  - Reset mid-operation aborts immediately; no strobe survives the reset edge.
- Outputs are Moore (decoded from state and op_q). Any output not listed for a state is 0.
- Opcodes: R=000000, ADDI=001000, ORI=001101, ANDI=001100, SLTI=001010, LW=100011, SW=101011, BEQ=000100, J=000010.
- sel_alu codes: 000 R-type (funct decides), 001 add, 010 or, 011 and, 100 slt, 101 sub.
- States, outputs and transitions:
  - RESET: -> FETCH after 1 cycle.
  - FETCH: mem_read=1, alu_src_b=01, sel_alu=001.
    - mem_ready=0: hold; ir_write=0, pc_write=0.
    - mem_ready=1: ir_write=1, pc_write=1 (pc_src=00), then -> DECODE.
  - DECODE: alu_src_b=11, sel_alu=001 (branch target into ALUOut). op_q<=opcode.
    - LW/SW -> MEMADDR; R -> EXEC_R; ADDI/ORI/ANDI/SLTI -> EXEC_I; BEQ -> BRANCH; J -> JUMP.
    - Any other opcode -> TRAP.
  - MEMADDR: alu_src_a=1, alu_src_b=10, sel_alu=001. LW -> MEMREAD; SW -> MEMWRITE.
  - MEMREAD: i_or_d=1, mem_read=1. Hold until mem_ready=1, then -> MEMWB.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
  - MEMWRITE: i_or_d=1, mem_write=1. Hold until mem_ready=1, then -> FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, sel_alu=000. -> RWB.
  - RWB: reg_write=1, reg_dst=1. -> FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10. sel_alu from op_q: ADDI 001, ORI 010, ANDI 011, SLTI 100. -> IWB.
  - IWB: reg_write=1, reg_dst=0. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sel_alu=101, pc_write_cond=1, pc_src=01. -> FETCH.
  - JUMP: pc_write=1, pc_src=10. -> FETCH.
  - TRAP: illegal=1; all other outputs 0. Absorbing; exits only via reset.
- Retire counter
  - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (on mem_ready), RWB, IWB, BRANCH or JUMP.
  - Wraps modulo 2^CNT_W.
- Latency in cycles, with mem_ready=1 immediately:
  - LW 5, SW 4, R 4, I 4, BEQ 3, J 3.
  - Each extra wait cycle in FETCH, MEMREAD or MEMWRITE adds 1.
- Strobe timing: mem_read/mem_write stay high continuously while waiting and drop the cycle after mem_ready is sampled high.
- opcode is sampled only in DECODE; later changes to opcode are ignored.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode localparams;
  - sel_alu code localparams, shared with the ALU control decoder;
  - alu_src_b and pc_src encodings;
  - the state enum, 4 bits.
- One natural sub-module: mc_opdec. It is combinational: opcode -> next-state class, legal flag and EXEC_I sel_alu. The FSM instantiates it twice, once for DECODE dispatch and once on op_q.

Test Plan:
- Reset then mem_ready=1, opcode=100011 (LW) -> states RESET,FETCH,DECODE,MEMADDR,MEMREAD,MEMWB,FETCH; reg_write=1 & mem_to_reg=1 only in MEMWB; instr_count=1.
- SW with mem_ready low 3 cycles in MEMWRITE -> mem_write=1 for exactly 4 cycles, i_or_d=1 throughout; instr_count increments once, after ready.
- ORI (001101) then SLTI (001010) -> sel_alu=010 then 100 in the respective EXEC_I cycles, sel_alu=001 in FETCH/DECODE; reg_dst=0 in IWB.
- BEQ (000100) -> BRANCH cycle shows sel_alu=101, pc_write_cond=1, pc_src=01, pc_write=0; back in FETCH next cycle.
- opcode=111111 in DECODE -> TRAP next cycle, illegal=1, all strobes 0 for 20 cycles; then rst_n pulse -> illegal=0, RESET.
- rst_n asserted asynchronously mid-MEMREAD with mem_read=1 -> mem_read=0 within the same cycle, before the next clk edge; op_q=0, instr_count=0.
